instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Requester side of the instruction-memory read interface: owns the PC, drives word address Dir,
//  captures returned Inst and hands decode a buffered (pc, inst) stream with valid/stall handshake.
//  Sits between Instruction_Memory and the decode stage; absorbs fixed memory read latency,
//  decode back-pressure and branch redirects.
// PARAMETERS
//  RESET_PC    32'h0000_0000  byte address fetched first after reset
//  MEM_LAT     1              cycles from Dir presented to Inst valid (1..4)
//  FIFO_DEPTH  4              entries in fetch buffer (power of 2, >= MEM_LAT+1)
// PORTS
//  CLK            in   1   clock, rising edge
//  RST            in   1   reset; one clock, reset is asynchronous and active-low
//  Dir            out  32  word address to memory = {2'b00, pc_q[31:2]}
//  mem_req        out  1   Dir valid this cycle; memory returns Inst MEM_LAT cycles later
//  Inst           in   32  instruction data from memory
//  stall          in   1   decode cannot accept this cycle
//  branch_taken   in   1   redirect request (one-cycle pulse)
//  branch_target  in   32  redirect byte address
//  if_valid       out  1   if_inst/if_pc hold a valid entry
//  if_inst        out  32  instruction at FIFO head
//  if_pc          out  32  byte PC of if_inst
//  misalign       out  1   sticky misaligned-target flag (macro only; else tied 0)
// BEHAVIOUR
//  Reset (RST=0, async): pc_q=RESET_PC, FIFO empty, in-flight cleared, state=BOOT; Dir={2'b00,RESET_PC[31:2]},
//   mem_req=0, if_valid=0, if_inst=0, if_pc=0, misalign=0. Reset mid-operation discards everything.
//  FSM: BOOT -> FETCH after one cycle with RST high (no request in BOOT). FETCH -> HALT only via macro.
//   HALT left only by reset.
//  Issue (FETCH): mem_req=1 iff fifo_count + inflight_count < FIFO_DEPTH (credit rule, no overflow
//   ever). On issue pc_q += 4 (wraps 32'hFFFF_FFFC -> 0); the PC is tagged into an MEM_LAT-deep
//   valid/pc shift pipeline.
//  Return: when pipeline tail valid, {Inst, tag_pc} written to FIFO that cycle; write never blocked.
//  Pop: if_valid && !stall pops head at clock edge. Push into empty FIFO appears on if_valid next
//   cycle (total issue->if_valid latency = MEM_LAT+1). Simultaneous push and pop: count unchanged.
//  Full: with stall held, issue stops once credit exhausted; exactly FIFO_DEPTH entries retained,
//   order preserved, no drops, no duplicates.
//  Redirect: branch_taken in FETCH -> on that edge FIFO flushed, in-flight valids cleared (late data
//   dropped), pc_q=branch_target; no issue in the redirect cycle; first target request next cycle.
//   if_valid=0 the cycle after redirect. Redirect wins over simultaneous pop/push/stall.
//  branch_taken in BOOT or HALT ignored. Target low bits: see CONFIGURATION.
//  Dir always reflects pc_q (also when mem_req=0); memory may ignore it then.
// CONFIGURATION
//  IFU_MISALIGN_TRAP_EN defined: redirect with branch_target[1:0]!=0 -> flush as normal, pc_q unchanged,
//   misalign=1 (sticky), state=HALT (mem_req=0, FIFO stays empty). Aligned targets behave as above.
//  Not defined: branch_target[1:0] forced to 2'b00, misalign tied 0, HALT unreachable.
// TESTING
//  T1 reset/boot: RST low 3 cycles -> outputs at reset values; after release 1 BOOT cycle, then
//   mem_req=1, Dir=0,1,2,3...; memory model mem[i]=32'h1000_0000+i -> if_inst stream 0x10000000,
//   0x10000001,... with if_pc 0,4,8; first if_valid MEM_LAT+1 cycles after first mem_req.
//  T2 back-pressure: stall=1 for 10 cycles -> exactly 4 entries held (FIFO_DEPTH=4), mem_req low once
//   credit used; release -> pcs 0,4,8,12,16 contiguous, none lost/repeated.
//  T3 redirect: at if_pc=8 pulse branch_taken with target 32'h40 -> next cycle if_valid=0, following
//   Dir=16, if_pc resumes at 0x40 with inst 0x10000010; no older pc appears after redirect.
//  T4 redirect with data in flight (MEM_LAT=3) and stall=1 -> all in-flight returns discarded,
//   FIFO empty, then stream from target.
//  T5 async reset mid-stream: drop RST between edges -> outputs reset immediately, restart at
//   RESET_PC=32'h100 (Dir=32'h40) after BOOT.
//  T6 macro on: target 32'h42 -> misalign=1, mem_req=0 forever, if_valid=0 after flush;
//   macro off: same stimulus fetches from 0x40.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// ============================================================================
// instruction_fetch_unit
// ----------------------------------------------------------------------------
// Requester side of the instruction-memory read port. It owns the PC, issues
// word addresses to a fixed-latency memory and collects the returned words
// into a small FIFO. Decode drains that FIFO through a valid/stall handshake.
//
// Flow control is credit based. A request is issued only while
// (buffered + in-flight) < FIFO_DEPTH. Because of this, a returning word
// always has a free slot and the return path never needs to block.
//
// Optional feature (compile-time macro IFU_MISALIGN_TRAP_EN):
//   Defined   : a redirect to a target that is not word aligned flushes the
//               pipe, sets the sticky misalign flag and parks the unit in HALT.
//   Undefined : the low two target bits are ignored and misalign is tied 0.
//
// Ports
//   CLK, RST                     clock (rising edge), async active-low reset
//   Dir[31:0]                    word address {2'b00, pc_q[31:2]}
//   mem_req                      Dir is a real request this cycle
//   Inst[31:0]                   memory data, valid MEM_LAT cycles after request
//   stall                        decode cannot accept the head entry
//   branch_taken, branch_target  redirect pulse and byte target address
//   if_valid, if_inst, if_pc     FIFO head presented to decode
//   misalign                     sticky misaligned-target flag
// ============================================================================
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          MEM_LAT    = 1,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RST,
    output logic [31:0] Dir,
    output logic        mem_req,
    input  logic [31:0] Inst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic        misalign
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {BOOT, FETCH, HALT} state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q;
    logic [31:0]   target_pc;
    logic          redirect, trap, credit, push, pop;

    // Per-stage valid/PC tags for requests still in flight in the memory.
    logic [MEM_LAT:1] vld_pipe;
    logic [31:0]      pc_pipe [MEM_LAT:1];
    logic [AW:0]      inflight;

    logic [31:0]   buf_inst [FIFO_DEPTH];
    logic [31:0]   buf_pc   [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   fifo_count;

    assign redirect = (state_q == FETCH) && branch_taken;

`ifdef IFU_MISALIGN_TRAP_EN
    logic misalign_q;
    assign trap      = redirect && (branch_target[1:0] != 2'b00);
    assign target_pc = branch_target;
    assign misalign  = misalign_q;
`else
    logic unused_tgt_bits;
    assign unused_tgt_bits = ^branch_target[1:0];
    assign trap      = 1'b0;
    assign target_pc = {branch_target[31:2], 2'b00};
    assign misalign  = 1'b0;
`endif

    always_comb begin
        inflight = '0;
        for (int i = 1; i <= MEM_LAT; i++)
            inflight = inflight + (AW+1)'(vld_pipe[i]);
    end

    assign credit = ({1'b0, fifo_count} + {1'b0, inflight}) < (AW+2)'(FIFO_DEPTH);

    // Next state and issue decision.
    always_comb begin
        state_d = state_q;
        mem_req = 1'b0;
        case (state_q)
            BOOT:  state_d = FETCH;
            FETCH: begin
                if (trap)
                    state_d = HALT;
                else if (!redirect && credit)
                    mem_req = 1'b1;
            end
            HALT:  state_d = HALT;
            default: state_d = BOOT;
        endcase
    end

    assign Dir = {2'b00, pc_q[31:2]};

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            if (redirect && !trap)
                pc_q <= target_pc;
            else if (mem_req)
                pc_q <= pc_q + 32'd4;
        end
    end

`ifdef IFU_MISALIGN_TRAP_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            misalign_q <= 1'b0;
        else if (trap)
            misalign_q <= 1'b1;
    end
`endif

    // Latency pipe: a redirect kills every tag so late returns are dropped.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            vld_pipe <= '0;
            for (int i = 1; i <= MEM_LAT; i++)
                pc_pipe[i] <= '0;
        end else if (redirect) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= mem_req;
            pc_pipe[1]  <= pc_q;
            for (int i = 2; i <= MEM_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                pc_pipe[i]  <= pc_pipe[i-1];
            end
        end
    end

    // Return write never blocks; a redirect overrides both push and pop.
    assign push = vld_pipe[MEM_LAT] && !redirect;
    assign pop  = if_valid && !stall && !redirect;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else if (redirect) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Storage needs no reset; the outputs are gated by if_valid.
    always_ff @(posedge CLK) begin
        if (push) begin
            buf_inst[wr_ptr] <= Inst;
            buf_pc[wr_ptr]   <= pc_pipe[MEM_LAT];
        end
    end

    assign if_valid = (fifo_count != '0);
    assign if_inst  = if_valid ? buf_inst[rd_ptr] : 32'h0;
    assign if_pc    = if_valid ? buf_pc[rd_ptr]   : 32'h0;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ============================================================================
// tb_instruction_fetch_unit
// ----------------------------------------------------------------------------
// Drives the fetch unit with directed and random stall/redirect/reset
// traffic. A latency-accurate memory model answers requests with
// mem[i] = 32'h1000_0000 + i. A queue-based reference model predicts every
// output, cycle by cycle.
//
// The bench honours IFU_MISALIGN_TRAP_EN in the same way as the design.
// ============================================================================
module tb_instruction_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam int          MEM_LAT  = 3;
    localparam int          DEPTH    = 4;
    localparam int          M_BOOT = 0, M_FETCH = 1, M_HALT = 2;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [31:0] Dir, Inst, branch_target = 32'h0, if_inst, if_pc;
    logic        mem_req, stall = 1'b0, branch_taken = 1'b0, if_valid, misalign;

    always #5 CLK = ~CLK;

    instruction_fetch_unit #(
        .RESET_PC(RESET_PC), .MEM_LAT(MEM_LAT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .CLK(CLK), .RST(RST), .Dir(Dir), .mem_req(mem_req), .Inst(Inst),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .misalign(misalign)
    );

    // Fixed-latency memory. When no request was made, it returns a poison word.
    logic [31:0] maddr [MEM_LAT] = '{default: 32'h0};
    logic        mvld  [MEM_LAT] = '{default: 1'b0};
    always @(posedge CLK) begin
        maddr[0] <= Dir;
        mvld[0]  <= mem_req;
        for (int i = MEM_LAT - 1; i > 0; i--) begin
            maddr[i] <= maddr[i-1];
            mvld[i]  <= mvld[i-1];
        end
    end
    assign Inst = mvld[MEM_LAT-1] ? 32'h1000_0000 + maddr[MEM_LAT-1] : 32'hDEAD_BEEF;

    // Reference model state.
    int          mstate = M_BOOT;
    logic [31:0] mpc    = RESET_PC;
    logic        mmis   = 1'b0;
    logic [31:0] fq [$];            // buffered PCs, head first
    logic [31:0] iq [$];            // in-flight PCs
    int          ic [$];            // cycle each in-flight PC was issued
    int          cyc = 0;
    int          nvec = 0, nerr = 0;

    function automatic logic exp_req();
        return (mstate == M_FETCH) && !branch_taken && ((fq.size() + iq.size()) < DEPTH);
    endfunction

    task automatic model_reset();
        mstate = M_BOOT; mpc = RESET_PC; mmis = 1'b0;
        fq.delete(); iq.delete(); ic.delete();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s cycle %0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [31:0] hpc;
        chk("mem_req", 32'(mem_req), 32'(exp_req()));
        chk("Dir", Dir, {2'b00, mpc[31:2]});
        chk("if_valid", 32'(if_valid), 32'(fq.size() > 0));
        chk("misalign", 32'(misalign), 32'(mmis));
        if (fq.size() > 0) begin
            hpc = fq[0];
            chk("if_pc", if_pc, hpc);
            chk("if_inst", if_inst, 32'h1000_0000 + {2'b00, hpc[31:2]});
        end else if (!RST) begin
            chk("rst_if_pc", if_pc, 32'h0);
            chk("rst_if_inst", if_inst, 32'h0);
        end
        nvec++;
    endtask

    // Advance the model across the coming rising edge (RST high).
    task automatic model_edge();
        logic req;
        logic bad;
        req = exp_req();
        case (mstate)
            M_BOOT: mstate = M_FETCH;
            M_FETCH: begin
                if (branch_taken) begin
                    fq.delete(); iq.delete(); ic.delete();
`ifdef IFU_MISALIGN_TRAP_EN
                    bad = (branch_target[1:0] != 2'b00);
`else
                    bad = 1'b0;
`endif
                    if (bad) begin
                        mmis = 1'b1; mstate = M_HALT;
                    end else begin
                        mpc = branch_target & 32'hFFFF_FFFC;
                    end
                end else begin
                    if (fq.size() > 0 && !stall) void'(fq.pop_front());
                    while (ic.size() > 0 && ic[0] + MEM_LAT == cyc) begin
                        fq.push_back(iq.pop_front());
                        void'(ic.pop_front());
                    end
                    if (req) begin
                        iq.push_back(mpc); ic.push_back(cyc); mpc = mpc + 32'd4;
                    end
                end
            end
            default: ;
        endcase
    endtask

    task automatic cycle(input logic r, input logic s, input logic b, input logic [31:0] t);
        @(negedge CLK);
        RST = r; stall = s; branch_taken = b; branch_target = t;
        if (!r) model_reset();
        #1;
        check_all();
        if (r) model_edge();
        cyc++;
    endtask

    initial begin
        logic [31:0] t;
        logic        s, b, r;
        model_reset();

        // Reset held, then boot. The first post-reset cycle is BOOT and ignores the branch.
        repeat (3) cycle(1'b0, 1'b0, 1'b1, 32'h80);
        cycle(1'b1, 1'b0, 1'b1, 32'h80);
        repeat (20) cycle(1'b1, 1'b0, 1'b0, 32'h0);

        // Back-pressure until credit is exhausted, then drain.
        repeat (12) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        repeat (10) cycle(1'b1, 1'b0, 1'b0, 32'h0);

        // Redirect while stalled with returns still in flight.
        repeat (2) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 32'h40);
        repeat (12) cycle(1'b1, 1'b0, 1'b0, 32'h0);

        // PC wrap past the top of the address space.
        cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF0);
        repeat (14) cycle(1'b1, 1'b0, 1'b0, 32'h0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 99) != 0);
            s = ($urandom_range(0, 9) < 3);
            b = ($urandom_range(0, 19) == 0);
            t = $urandom();
            if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFE0 | (t & 32'h1F);
`ifdef IFU_MISALIGN_TRAP_EN
            t[1:0] = 2'b00;
`endif
            cycle(r, s, b, t);
        end

        // Async reset dropped between edges, then restart from RESET_PC.
        repeat (6) cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (12) cycle(1'b1, 1'b0, 1'b0, 32'h0);

        // Misaligned target: a trap when the feature is built in, otherwise an aligned fetch.
        cycle(1'b1, 1'b0, 1'b1, 32'h42);
        repeat (15) cycle(1'b1, 1'b0, 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
